sp_ram_burst_ctrl: RTL

Burst controller that sits directly upstream of the 64×8 single-port RAM and owns its `write_en`/`addr`/`din` inputs and its `dout` output. It accepts one command at a time: a start address, a length, and a direction. A write command streams data from a valid/ready source into consecutive RAM words. A read command streams consecutive RAM words out to a sink with a last-beat marker. The RAM has a registered read port with one-cycle latency.

---
 rtl/sp_ram_burst_ctrl_if.sv | 43 ++++
 rtl/sp_ram_burst_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sp_ram_burst_ctrl_if.sv
// Bus bundle between the burst controller, its command/data clients and the
// 64x8 single-port RAM.
//
// Handshakes: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; a write beat transfers on a rising edge where
// wr_valid and wr_ready are both high. A source holds valid and payload stable
// until it sees ready, and ready never depends combinationally on valid. Read
// beats (rd_valid) carry no backpressure: the sink must take every beat.
interface sp_ram_burst_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              done;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  // Upstream clients plus the RAM: everything the controller does not drive.
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, ram_dout,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done,
    input  ram_we, ram_addr, ram_din
  );

  // The burst controller.
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, ram_dout,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done,
    output ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/sp_ram_burst_ctrl.sv
// Burst controller in front of a single-port RAM with a one-cycle registered
// read port. Accepts one command at a time and streams consecutive words to
// or from the RAM, wrapping modulo the RAM depth.
module sp_ram_burst_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  sp_ram_burst_ctrl_if.slave bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;          // next word to touch
  logic [ADDR_W-1:0] cnt_q, cnt_d;            // beats left minus one
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              done_q, done_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              wr_ready_q, wr_ready_d;

  // Next-state and next-output decode; every control output is computed here
  // from the state being entered and registered below.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    din_d      = din_q;
    we_d       = 1'b0;
    rd_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cnt_d = bus.cmd_len;
          if (bus.cmd_write) begin
            state_d = S_WRITE;
            addr_d  = bus.cmd_addr;
          end else begin
            // The first read address goes out in the very next cycle, so it
            // is loaded into the RAM address register right away.
            state_d    = S_READ;
            ram_addr_d = bus.cmd_addr;
            addr_d     = bus.cmd_addr + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (bus.wr_valid) begin
          we_d       = 1'b1;
          ram_addr_d = addr_q;
          din_d      = bus.wr_data;
          addr_d     = addr_q + 1'b1;
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_READ: begin
        // An address is on the RAM this cycle; its data shows up next cycle.
        rd_valid_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          ram_addr_d = addr_q;
          addr_d     = addr_q + 1'b1;
          cnt_d      = cnt_q - 1'b1;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    wr_ready_d  = (state_d == S_WRITE);
    rd_last_d   = (state_d == S_DRAIN);
    done_d      = (state_d == S_DRAIN) || (state_d == S_DONE);
  end

  // State and registered outputs; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      din_q       <= din_d;
      we_q        <= we_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  // The idle flag is already set during reset so the controller can take a
  // command in the first cycle after reset; it is masked while rst is high.
  assign bus.cmd_ready = cmd_ready_q & ~rst;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_data   = bus.ram_dout;
  assign bus.done      = done_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = din_q;
  assign dbg_state     = state_q;

endmodule
